// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request sequencer between the instruction memory port and the fetch FIFO.
// Optional macro IBEX_FETCH_STALL_CNT_EN adds gnt_stall_cnt_o (saturating grant-stall count).
module ibex_fetch_req_ctrl #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
`ifdef IBEX_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]         gnt_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_GNT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_REQS-1:0] r_outst;
  logic [NUM_REQS-1:0] r_disc;
  logic [31:2]         r_fetch_addr;
  logic [31:2]         r_hold_addr;
  logic                r_pend_disc;
  logic [31:0]         r_addr_q [NUM_REQS];

  logic                w_pop;
  logic                w_push;
  logic                w_push_disc;
  logic                w_can_req;
  logic [3:0]          w_cnt;
  logic [NUM_REQS-1:0] w_outst_pop;
  logic [NUM_REQS-1:0] w_disc_br;
  logic [NUM_REQS-1:0] w_disc_pop;
  logic [NUM_REQS-1:0] w_slot;
  logic [NUM_REQS-1:0] w_outst_next;
  logic [NUM_REQS-1:0] w_disc_next;
  logic [31:0]         w_addr_shift [NUM_REQS];

  function automatic logic [3:0] popcnt(input logic [NUM_REQS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_REQS; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  assign w_pop       = instr_rvalid_i;
  assign w_push      = instr_req_o & instr_gnt_i;
  // A request still waiting for its grant when the branch hit belongs to the old stream.
  assign w_push_disc = branch_i | r_pend_disc;

  // Per-slot tracking: branch marks, pop shifts down, push fills the lowest free slot.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_slot
    assign w_disc_br[gi] = r_disc[gi] | (branch_i & r_outst[gi]);
    if (gi < NUM_REQS - 1) begin : g_mid
      assign w_outst_pop[gi]  = w_pop ? r_outst[gi+1]   : r_outst[gi];
      assign w_disc_pop[gi]   = w_pop ? w_disc_br[gi+1] : w_disc_br[gi];
      assign w_addr_shift[gi] = w_pop ? r_addr_q[gi+1]  : r_addr_q[gi];
    end else begin : g_top
      assign w_outst_pop[gi]  = w_pop ? 1'b0  : r_outst[gi];
      assign w_disc_pop[gi]   = w_pop ? 1'b0  : w_disc_br[gi];
      assign w_addr_shift[gi] = w_pop ? '0    : r_addr_q[gi];
    end
    if (gi == 0) begin : g_first
      assign w_slot[gi] = w_push & ~w_outst_pop[gi];
    end else begin : g_rest
      assign w_slot[gi] = w_push & ~w_outst_pop[gi] & w_outst_pop[gi-1];
    end
    assign w_outst_next[gi] = w_outst_pop[gi] | w_slot[gi];
    assign w_disc_next[gi]  = w_disc_pop[gi] | (w_slot[gi] & w_push_disc);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_addr_q[gi] <= '0;
      end else begin
        r_addr_q[gi] <= w_slot[gi] ? instr_addr_o : w_addr_shift[gi];
      end
    end
  end

  // Budget includes this cycle's pop and push so a back-to-back grant never overshoots.
  assign w_cnt     = popcnt(fifo_busy_i) + popcnt(w_outst_next);
  assign w_can_req = req_i & (w_cnt < 4'(NUM_REQS));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_can_req) w_state_next = ST_REQ;
      end
      ST_REQ, ST_WAIT_GNT: begin
        if (instr_gnt_i) w_state_next = w_can_req ? ST_REQ : ST_IDLE;
        else             w_state_next = ST_WAIT_GNT;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = '0;
    case (r_state)
      ST_REQ: begin
        instr_req_o  = 1'b1;
        instr_addr_o = {r_fetch_addr, 2'b00};
      end
      ST_WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = {r_hold_addr, 2'b00};
      end
      default: begin
        instr_req_o  = 1'b0;
        instr_addr_o = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst      <= '0;
      r_disc       <= '0;
      r_fetch_addr <= '0;
      r_hold_addr  <= '0;
      r_pend_disc  <= 1'b0;
    end else begin
      r_outst <= w_outst_next;
      r_disc  <= w_disc_next;
      if (branch_i) begin
        r_fetch_addr <= branch_addr_i[31:2];
      end else if (w_push & ~r_pend_disc) begin
        r_fetch_addr <= r_fetch_addr + 30'd1;
      end
      // Freeze the presented address so a branch cannot move an ungranted request.
      if ((r_state == ST_REQ) & ~instr_gnt_i) r_hold_addr <= r_fetch_addr;
      r_pend_disc <= (instr_req_o & ~instr_gnt_i) ? (r_pend_disc | branch_i) : 1'b0;
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_i ? branch_addr_i : r_addr_q[0];
  assign fifo_valid_o = instr_rvalid_i & ~r_disc[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | r_outst[0];

`ifdef IBEX_FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (instr_req_o & ~instr_gnt_i & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign gnt_stall_cnt_o = r_stall_cnt;
`endif

  a_rvalid_needs_outst : assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> r_outst[0]);
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (w_push & ~w_pop) |-> ~r_outst[NUM_REQS-1]);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed self-checking bench for ibex_fetch_req_ctrl (NUM_REQS=2).
// Stall-counter checks compile only when IBEX_FETCH_STALL_CNT_EN is defined.
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic [1:0]  fifo_busy_i = '0;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        busy_o;
`ifdef IBEX_FETCH_STALL_CNT_EN
  logic [15:0] gnt_stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
`ifdef IBEX_FETCH_STALL_CNT_EN
    ,
    .gnt_stall_cnt_o(gnt_stall_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = 0; branch_i = 0; branch_addr_i = '0; fifo_busy_i = '0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1; req_i = 1;
    tick();
    tick();
    n_tests++;
    if (instr_req_o !== 1'b0 || busy_o !== 1'b0 || instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle req=%b busy=%b addr=%h expected 0 0 00000000", instr_req_o, busy_o, instr_addr_o);
    end
    n_tests++;
    if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b0 || fifo_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fifo valid=%b clear=%b addr=%h expected 0 0 00000000", fifo_valid_o, fifo_clear_o, fifo_addr_o);
    end
    // Start a request, then reset mid-operation with one outstanding.
    rst_i = 0; instr_gnt_i = 1;
    tick();
    tick();
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midop_busy got=%b expected 1", busy_o);
    end
    rst_i = 1; req_i = 0; instr_gnt_i = 0;
    tick();
    n_tests++;
    if (busy_o !== 1'b0 || instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop_drop busy=%b req=%b expected 0 0", busy_o, instr_req_o);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_streaming();
    logic [31:0] exp_a;
    do_reset();
    req_i = 1; instr_gnt_i = 1; branch_i = 1; branch_addr_i = 32'h100;
    #1;
    n_tests++;
    if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h100 || instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_clear clear=%b addr=%h req=%b expected 1 00000100 0", fifo_clear_o, fifo_addr_o, instr_req_o);
    end
    tick();
    branch_i = 0;
    for (int k = 0; k < 3; k++) begin
      req_i = (k < 2);
      instr_rvalid_i = (k > 0);
      instr_rdata_i = 32'hA0 + 32'(k) - 32'd1;
      #1;
      exp_a = 32'h100 + 32'(4 * k);
      n_tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== exp_a) begin
        n_fail++;
        $display("FAIL stream_addr k=%0d req=%b addr=%h expected 1 %h", k, instr_req_o, instr_addr_o, exp_a);
      end
      if (k > 0) begin
        exp_a = 32'h100 + 32'(4 * (k - 1));
        n_tests++;
        if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== instr_rdata_i || fifo_addr_o !== exp_a) begin
          n_fail++;
          $display("FAIL stream_resp k=%0d valid=%b rdata=%h faddr=%h expected 1 %h %h", k, fifo_valid_o, fifo_rdata_o, fifo_addr_o, instr_rdata_i, exp_a);
        end
      end
      $display("[TB] stream k=%0d addr=%h valid=%b", k, instr_addr_o, fifo_valid_o);
      tick();
    end
    req_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hA2;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h108 || fifo_rdata_o !== 32'hA2) begin
      n_fail++;
      $display("FAIL stream_last req=%b valid=%b faddr=%h rdata=%h expected 0 1 00000108 000000a2", instr_req_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_idle busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    req_i = 1;
    tick();
    instr_gnt_i = 1; fifo_busy_i = 2'b11;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_first req=%b addr=%h expected 1 00000000", instr_req_o, instr_addr_o);
    end
    tick();
    instr_gnt_i = 0;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_throttle req=%b busy=%b expected 0 1", instr_req_o, busy_o);
    end
    tick();
    instr_rvalid_i = 1; instr_rdata_i = 32'hB0;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hB0) begin
      n_fail++;
      $display("FAIL bp_resp req=%b valid=%b rdata=%h expected 0 1 000000b0", instr_req_o, fifo_valid_o, fifo_rdata_o);
    end
    tick();
    instr_rvalid_i = 0; fifo_busy_i = 2'b01;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_still_idle req=%b expected 0", instr_req_o);
    end
    tick();
    instr_gnt_i = 1; req_i = 0;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_resume req=%b addr=%h expected 1 00000004", instr_req_o, instr_addr_o);
    end
    tick();
    instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hB1;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h4 || instr_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resp2 valid=%b faddr=%h req=%b expected 1 00000004 0", fifo_valid_o, fifo_addr_o, instr_req_o);
    end
    $display("[TB] back_pressure resumed addr=00000004");
    tick();
    clear_inputs();
  endtask

  task automatic test_held_request();
    do_reset();
    req_i = 1;
    tick();
    #1;
    n_tests++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL held_start req=%b addr=%h expected 1 00000000", instr_req_o, instr_addr_o);
    end
    tick();
    branch_i = 1; branch_addr_i = 32'h2002;
    #1;
    n_tests++;
    if (instr_addr_o !== 32'h0 || fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h2002) begin
      n_fail++;
      $display("FAIL held_branch addr=%h clear=%b faddr=%h expected 00000000 1 00002002", instr_addr_o, fifo_clear_o, fifo_addr_o);
    end
    tick();
    branch_i = 0;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL held_stable req=%b addr=%h expected 1 00000000", instr_req_o, instr_addr_o);
    end
    tick();
    instr_gnt_i = 1;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL held_gnt req=%b addr=%h expected 1 00000000", instr_req_o, instr_addr_o);
    end
    tick();
    req_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD;
    #1;
    n_tests++;
    if (instr_addr_o !== 32'h2000 || fifo_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL held_newreq addr=%h valid=%b expected 00002000 0", instr_addr_o, fifo_valid_o);
    end
    tick();
    instr_gnt_i = 0; instr_rdata_i = 32'hC0;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h2000 || fifo_rdata_o !== 32'hC0) begin
      n_fail++;
      $display("FAIL held_newresp valid=%b faddr=%h rdata=%h expected 1 00002000 000000c0", fifo_valid_o, fifo_addr_o, fifo_rdata_o);
    end
    $display("[TB] held_request new stream addr=00002000");
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_outstanding();
    do_reset();
    req_i = 1; instr_gnt_i = 1;
    tick();
    tick();
    tick();
    instr_gnt_i = 0; branch_i = 1; branch_addr_i = 32'h300;
    #1;
    n_tests++;
    if (instr_req_o !== 1'b0 || busy_o !== 1'b1 || fifo_clear_o !== 1'b1) begin
      n_fail++;
      $display("FAIL brout_full req=%b busy=%b clear=%b expected 0 1 1", instr_req_o, busy_o, fifo_clear_o);
    end
    tick();
    branch_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hE0;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL brout_drop1 valid=%b expected 0", fifo_valid_o);
    end
    tick();
    instr_rdata_i = 32'hE1; instr_gnt_i = 1; req_i = 0;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin
      n_fail++;
      $display("FAIL brout_drop2 valid=%b req=%b addr=%h expected 0 1 00000300", fifo_valid_o, instr_req_o, instr_addr_o);
    end
    tick();
    instr_gnt_i = 0; instr_rdata_i = 32'hE2;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hE2 || fifo_addr_o !== 32'h300) begin
      n_fail++;
      $display("FAIL brout_keep valid=%b rdata=%h faddr=%h expected 1 000000e2 00000300", fifo_valid_o, fifo_rdata_o, fifo_addr_o);
    end
    $display("[TB] branch_outstanding third rvalid valid=%b", fifo_valid_o);
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_rvalid();
    do_reset();
    req_i = 1;
    tick();
    instr_gnt_i = 1; req_i = 0;
    tick();
    instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h77; branch_i = 1; branch_addr_i = 32'h40;
    #1;
    n_tests++;
    if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b1) begin
      n_fail++;
      $display("FAIL brval_drop valid=%b clear=%b expected 0 1", fifo_valid_o, fifo_clear_o);
    end
    $display("[TB] branch_rvalid valid=%b", fifo_valid_o);
    tick();
    clear_inputs();
  endtask

  task automatic test_wrap_error();
    do_reset();
    req_i = 1; instr_gnt_i = 1; branch_i = 1; branch_addr_i = 32'hFFFF_FFFE;
    tick();
    branch_i = 0;
    #1;
    n_tests++;
    if (instr_addr_o !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top addr=%h expected fffffffc", instr_addr_o);
    end
    tick();
    req_i = 0; instr_rvalid_i = 1; instr_err_i = 1; instr_rdata_i = 32'h55;
    #1;
    n_tests++;
    if (instr_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_zero addr=%h expected 00000000", instr_addr_o);
    end
    n_tests++;
    if (fifo_err_o !== 1'b1 || fifo_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_push err=%b valid=%b expected 1 1", fifo_err_o, fifo_valid_o);
    end
    tick();
    instr_gnt_i = 0; instr_err_i = 0;
    #1;
    n_tests++;
    if (fifo_err_o !== 1'b0 || fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL err_clean err=%b valid=%b faddr=%h expected 0 1 00000000", fifo_err_o, fifo_valid_o, fifo_addr_o);
    end
    $display("[TB] wrap_error addr wrapped to 00000000");
    tick();
    clear_inputs();
  endtask

`ifdef IBEX_FETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    req_i = 1;
    tick();
    req_i = 0;
    repeat (5) tick();
    n_tests++;
    if (gnt_stall_cnt_o !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_cnt5 got=%0d expected 5", gnt_stall_cnt_o);
    end
    repeat (70000) tick();
    n_tests++;
    if (gnt_stall_cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_sat got=%h expected ffff", gnt_stall_cnt_o);
    end
    $display("[TB] stall_cnt=%h", gnt_stall_cnt_o);
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_held_request();
    test_branch_outstanding();
    test_branch_rvalid();
    test_wrap_error();
`ifdef IBEX_FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_req_ctrl.md
Name: ibex_fetch_req_ctrl

Overview:
- Request sequencer that sits between the instruction memory port and the fetch FIFO body.
- Issues word-aligned fetch requests with a req/gnt/rvalid handshake and keeps up to NUM_REQS requests outstanding.
- Throttles requests against FIFO occupancy and pushes responses into the FIFO.
- On a branch, clears the FIFO and discards responses that belong to the old instruction stream.

Parameters:
NUM_REQS, 2, max outstanding memory requests; must equal the FIFO's NUM_REQS (range 1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  fetch enable from core
branch_i  in  1  redirect fetch; one-cycle pulse
branch_addr_i  in  32  redirect target, halfword aligned
fifo_busy_i  in  NUM_REQS  FIFO upper-entry occupancy
fifo_clear_o  out  1  FIFO clear
fifo_valid_o  out  1  push response into FIFO
fifo_addr_o  out  32  FIFO address (target on clear)
fifo_rdata_o  out  32  response data to FIFO
fifo_err_o  out  1  response error to FIFO
instr_req_o  out  1  memory request
instr_gnt_i  in  1  memory grant
instr_addr_o  out  32  memory word address, [1:0]=0
instr_rvalid_i  in  1  memory response valid
instr_rdata_i  in  32  memory response data
instr_err_i  in  1  memory response error
busy_o  out  1  request pending or response outstanding

Behaviour:
- Reset (rst_i=1 at clk_i edge): every output 0, state IDLE, all outstanding and discard bits 0, fetch_addr_q=0.
- State:
  - outst_q[NUM_REQS-1:0] is a thermometer of outstanding requests; bit 0 is the oldest.
  - disc_q[NUM_REQS-1:0] is aligned with outst_q; a set bit marks that response for discard.
- FSM states:
  - IDLE: instr_req_o=instr_addr_o=0. Move to REQ when can_req.
  - REQ: instr_req_o=1; instr_addr_o={fetch_addr_q[31:2],2'b00}. On gnt: push outstanding, fetch_addr_q+=4, stay in REQ if can_req, else IDLE. Without gnt: move to WAIT_GNT.
  - WAIT_GNT: instr_req_o=1 and instr_addr_o held stable until gnt, including across branch_i and req_i deassert. On gnt: push outstanding, then REQ if can_req, else IDLE.
- can_req = req_i & (popcount(fifo_busy_i) + popcount(outst_q) < NUM_REQS), evaluated with the same-cycle rvalid pop.
- Branch:
  - fifo_clear_o=branch_i, combinational.
  - fifo_addr_o=branch_addr_i during branch_i; otherwise the address of the oldest outstanding response.
  - fetch_addr_q <= {branch_addr_i[31:2],2'b00}.
  - All currently set outst_q bits set their disc_q bits.
  - A request in WAIT_GNT at branch time, or granted in the same cycle as branch_i, is marked discard when it is pushed. The first new-stream request goes out after that grant.
- Response:
  - instr_rvalid_i pops bit 0 of outst_q and disc_q (shift down).
  - fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i, same cycle, zero latency.
  - fifo_rdata_o=instr_rdata_i; fifo_err_o=instr_err_i.
- Simultaneous events:
  - rvalid and gnt in one cycle: pop and push both occur; count unchanged.
  - rvalid together with branch_i: data dropped.
- Address arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000.
- rvalid with outst_q==0 is illegal (assertion). Requests never exceed NUM_REQS outstanding.
- busy_o = instr_req_o | outst_q[0].
- Reset mid-operation: all tracking is dropped; later rvalid for pre-reset requests is out of contract.

Optional Feature:
- Macro IBEX_FETCH_STALL_CNT_EN defined:
  - Adds output gnt_stall_cnt_o[15:0].
  - Saturating count of cycles with instr_req_o & ~instr_gnt_i.
  - Cleared only by rst_i.
- Macro undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Streaming: reset, branch_i with branch_addr_i=0x100, req_i=1, gnt always 1, rvalid 1 cycle later, fifo_busy_i=0 -> instr_addr_o 0x100,0x104,0x108; fifo_valid_o each rvalid with matching rdata; outst_q never exceeds 2.
- Back-pressure: fifo_busy_i=2'b11 with one request outstanding -> instr_req_o=0 until the busy count drops; no lost or duplicated response.
- Held request: gnt low 3 cycles, branch_i to 0x2002 in the 2nd cycle -> instr_addr_o stays at the old address until gnt; that response is dropped (fifo_valid_o=0); next request to 0x2000; fifo_addr_o=0x2002 during the clear.
- Branch with 2 outstanding: branch_i while outst_q=2'b11 -> the next two rvalids are dropped; the third rvalid is pushed with data from the new target.
- Wrap and error: fetch_addr_q=0xFFFF_FFFC -> next request 0x0000_0000; rvalid with instr_err_i=1 -> fifo_err_o=1 and fifo_valid_o=1.
- Feature: with IBEX_FETCH_STALL_CNT_EN, 5 stalled cycles -> gnt_stall_cnt_o=5; forced 70000 stalls -> saturates at 0xFFFF.
